// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, reads the combinational ROM and hands one registered
// instruction per handshake to decode. Optional delivered-instruction counter under `FETCH_CNT_EN.
module fetch_sequencer #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned LAST_ADDR = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] LAST_PC    = PC_W'(LAST_ADDR);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic slot_free;
  logic xfer;

  assign slot_free = !instr_valid_q || instr_ready;
  assign xfer      = instr_valid_q && instr_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fault_d       = fault_q;

    if (redirect_valid) begin
      pc_d          = redirect_pc;
      instr_valid_d = 1'b0;
      state_d       = ST_RUN;
      halted_d      = 1'b0;
      fault_d       = 1'b0;
    end else if (state_q == ST_RUN) begin
      // With the slot free, any held word is being consumed, so stopping always empties the slot.
      if (slot_free) begin
        if (pc_q > LAST_PC) begin
          state_d       = ST_HALT;
          halted_d      = 1'b1;
          fault_d       = 1'b1;
          instr_valid_d = 1'b0;
        end else if (rom_data == '0) begin
          state_d       = ST_HALT;
          halted_d      = 1'b1;
          instr_valid_d = 1'b0;
        end else begin
          instr_d       = rom_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + PC_W'(1);
        end
      end
    end else begin
      if (xfer) begin
        instr_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC_V;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts every completed handshake, including one that coincides with a redirect flush.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, stall, redirect flush, halt word, out-of-range
// fault, delivered count and asynchronous reset, against a hand-written 21-word ROM image.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] rom [256];

`ifdef FETCH_CNT_EN
  localparam logic [15:0] EXP_CNT_RUN = 16'd20;
`else
  localparam logic [15:0] EXP_CNT_RUN = 16'd0;
`endif

  fetch_sequencer #(
    .PC_W      (8),
    .INSTR_W   (16),
    .RESET_PC  (0),
    .LAST_ADDR (20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'd0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'd0;
    #3;
    vectors++;
    if ({instr, instr_pc, instr_valid, halted, fault, fetch_count, rom_addr} !== {16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset: instr=%h pc=%h v=%b h=%b f=%b cnt=%h addr=%h, want all zero",
               instr, instr_pc, instr_valid, halted, fault, fetch_count, rom_addr);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if ({instr, instr_pc, instr_valid, halted} !== {rom[i], 8'(i), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stream[%0d]: instr=%h pc=%h v=%b h=%b, want instr=%h pc=%h v=1 h=0",
                 i, instr, instr_pc, instr_valid, halted, rom[i], 8'(i));
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({halted, fault, instr_valid, rom_addr} !== {1'b1, 1'b0, 1'b0, 8'd20}) begin
        errors++;
        $display("FAIL halt_word[%0d]: h=%b f=%b v=%b addr=%h, want h=1 f=0 v=0 addr=14",
                 k, halted, fault, instr_valid, rom_addr);
      end
    end
    vectors++;
    if (fetch_count !== EXP_CNT_RUN) begin
      errors++;
      $display("FAIL count_run: got %0d want %0d", fetch_count, EXP_CNT_RUN);
    end
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({instr, instr_pc, instr_valid, rom_addr} !== {16'h10a3, 8'd3, 1'b1, 8'd4}) begin
        errors++;
        $display("FAIL stall[%0d]: instr=%h pc=%h v=%b addr=%h, want 10a3 03 1 04",
                 k, instr, instr_pc, instr_valid, rom_addr);
      end
    end
    instr_ready = 1'b1;
    step();
    vectors++;
    if ({instr, instr_pc, instr_valid} !== {16'he236, 8'd4, 1'b1}) begin
      errors++;
      $display("FAIL stall_release: instr=%h pc=%h v=%b, want e236 04 1", instr, instr_pc, instr_valid);
    end
    step();
    vectors++;
    if ({instr, instr_pc, instr_valid} !== {16'h3100, 8'd5, 1'b1}) begin
      errors++;
      $display("FAIL back_to_back: instr=%h pc=%h v=%b, want 3100 05 1", instr, instr_pc, instr_valid);
    end
  endtask

  // Continues from test_stall with 0x3100 (pc 5) held.
  task automatic test_redirect();
    instr_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 8'd9;
    step();
    vectors++;
    if ({instr_valid, rom_addr} !== {1'b0, 8'd9}) begin
      errors++;
      $display("FAIL redirect_flush: v=%b addr=%h, want v=0 addr=09", instr_valid, rom_addr);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    step();
    vectors++;
    if ({instr, instr_pc, instr_valid} !== {16'hd040, 8'd9, 1'b1}) begin
      errors++;
      $display("FAIL redirect_fetch: instr=%h pc=%h v=%b, want d040 09 1", instr, instr_pc, instr_valid);
    end
  endtask

  task automatic test_halt_redirect();
    int budget;
    budget = 0;
    while (!halted && budget < 40) begin
      step();
      budget++;
    end
    vectors++;
    if ({halted, fault, instr_valid, rom_addr} !== {1'b1, 1'b0, 1'b0, 8'd20}) begin
      errors++;
      $display("FAIL reach_halt: h=%b f=%b v=%b addr=%h after %0d cycles, want h=1 f=0 v=0 addr=14",
               halted, fault, instr_valid, rom_addr, budget);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 8'd2;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({halted, instr_valid, rom_addr} !== {1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL halt_redirect: h=%b v=%b addr=%h, want h=0 v=0 addr=02", halted, instr_valid, rom_addr);
    end
    step();
    vectors++;
    if ({instr, instr_pc, instr_valid} !== {16'h1002, 8'd2, 1'b1}) begin
      errors++;
      $display("FAIL resume: instr=%h pc=%h v=%b, want 1002 02 1", instr, instr_pc, instr_valid);
    end
  endtask

  task automatic test_out_of_range();
    redirect_valid = 1'b1;
    redirect_pc    = 8'd21;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({halted, fault, instr_valid, rom_addr} !== {1'b1, 1'b1, 1'b0, 8'd21}) begin
        errors++;
        $display("FAIL oor[%0d]: h=%b f=%b v=%b addr=%h, want h=1 f=1 v=0 addr=15",
                 k, halted, fault, instr_valid, rom_addr);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc    = 8'd0;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({halted, fault} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL oor_clear: h=%b f=%b, want 0 0", halted, fault);
    end
    step();
    vectors++;
    if ({instr, instr_pc, instr_valid} !== {16'h1000, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL oor_resume: instr=%h pc=%h v=%b, want 1000 00 1", instr, instr_pc, instr_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({instr, instr_pc, instr_valid, halted, fault, fetch_count, rom_addr} !== {16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL async_reset: instr=%h pc=%h v=%b h=%b f=%b cnt=%h addr=%h, want all zero",
               instr, instr_pc, instr_valid, halted, fault, fetch_count, rom_addr);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hbeef;
    rom[0]  = 16'h1000; rom[1]  = 16'h1011; rom[2]  = 16'h1002; rom[3]  = 16'h10a3;
    rom[4]  = 16'he236; rom[5]  = 16'h3100; rom[6]  = 16'h2345; rom[7]  = 16'h4456;
    rom[8]  = 16'h5567; rom[9]  = 16'hd040; rom[10] = 16'h6678; rom[11] = 16'h7789;
    rom[12] = 16'h889a; rom[13] = 16'h99ab; rom[14] = 16'haabc; rom[15] = 16'hbbcd;
    rom[16] = 16'hccde; rom[17] = 16'hddef; rom[18] = 16'heef0; rom[19] = 16'hc0cd;
    rom[20] = 16'h0000;

    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt_redirect();
    test_out_of_range();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
